// File: rtl/flow_led_multi.sv
// LED pattern engine: rotate left/right, bounce and blink over LED_NUM outputs,
// stepping every STEP_CYC * 2^speed clocks while en is high.
module flow_led_multi #(
    parameter int LED_NUM  = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int STEP_MS  = 200
) (
    input  logic               sys_clk,
    input  logic               sys_res_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    localparam int STEP_CYC = CLK_FREQ / 1000 * STEP_MS;
    localparam int PW       = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYC - 1);

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [PW-1:0]      presc_q, presc_d;
    logic [2:0]         div_q, div_d;
    logic [2:0]         div_lim;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               dir_q, dir_d;
    mode_e              mode_q, mode_d;
    logic               pulse_q, pulse_d;
    logic               base_tick;
    logic               step;

    function automatic logic [LED_NUM-1:0] seed_of(input mode_e m);
        logic [LED_NUM-1:0] s;
        case (m)
            MODE_RIGHT: s = {1'b1, {(LED_NUM-1){1'b0}}};
            MODE_BLINK: s = {LED_NUM{1'b1}};
            default:    s = {{(LED_NUM-1){1'b0}}, 1'b1};
        endcase
        return s;
    endfunction

    function automatic logic [LED_NUM-1:0] rot_left(input logic [LED_NUM-1:0] l);
        return {l[LED_NUM-2:0], l[LED_NUM-1]};
    endfunction

    function automatic logic [LED_NUM-1:0] rot_right(input logic [LED_NUM-1:0] l);
        return {l[0], l[LED_NUM-1:1]};
    endfunction

    // Single lit LED walks toward an endpoint; dir flips on arrival so each
    // endpoint is shown exactly once per pass.
    function automatic logic [LED_NUM:0] bounce_next(input logic [LED_NUM-1:0] l,
                                                     input logic d);
        logic [LED_NUM-1:0] n;
        logic               nd;
        if (d == DIR_UP) begin
            n  = l << 1;
            nd = n[LED_NUM-1] ? DIR_DOWN : DIR_UP;
        end else begin
            n  = l >> 1;
            nd = n[0] ? DIR_UP : DIR_DOWN;
        end
        return {nd, n};
    endfunction

    always_comb begin
        case (speed)
            2'd0:    div_lim = 3'd0;
            2'd1:    div_lim = 3'd1;
            2'd2:    div_lim = 3'd3;
            default: div_lim = 3'd7;
        endcase
    end

    always_comb begin
        base_tick = en && (presc_q == PRESC_LAST);
        presc_d   = presc_q;
        div_d     = div_q;
        step      = 1'b0;

        if (!en) begin
            presc_d = '0;
            div_d   = '0;
        end else begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            if (base_tick) begin
                // A count left above the limit by a live speed change is
                // discarded without producing a step.
                if (div_q == div_lim) begin
                    step  = 1'b1;
                    div_d = '0;
                end else if (div_q > div_lim) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        logic [LED_NUM:0] b;
        led_d   = led_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        pulse_d = step;
        b       = bounce_next(led_q, dir_q);

        if (step) begin
            if (mode_e'(mode) != mode_q) begin
                mode_d = mode_e'(mode);
                led_d  = seed_of(mode_e'(mode));
                dir_d  = DIR_UP;
            end else begin
                case (mode_q)
                    MODE_LEFT:   led_d = rot_left(led_q);
                    MODE_RIGHT:  led_d = rot_right(led_q);
                    MODE_BOUNCE: begin
                        led_d = b[LED_NUM-1:0];
                        dir_d = b[LED_NUM];
                    end
                    default:     led_d = ~led_q;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_res_n) begin
        if (!sys_res_n) begin
            presc_q <= '0;
            div_q   <= '0;
            led_q   <= {{(LED_NUM-1){1'b0}}, 1'b1};
            dir_q   <= DIR_UP;
            mode_q  <= MODE_LEFT;
            pulse_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
        end
    end

    assign led        = led_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_flow_led_multi.sv
// Scoreboard bench for flow_led_multi with STEP_CYC = 4 and four LEDs.
module tb_flow_led_multi;

    logic       sys_clk = 1'b0;
    logic       sys_res_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic [3:0] led;
    logic       step_pulse;

    always #5 sys_clk = ~sys_clk;

    flow_led_multi #(
        .LED_NUM (4),
        .CLK_FREQ(1000),
        .STEP_MS (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_res_n (sys_res_n),
        .en        (en),
        .mode      (mode),
        .speed     (speed),
        .led       (led),
        .step_pulse(step_pulse)
    );

    typedef struct {
        logic [3:0] led;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [3:0] l, input int g);
        exp_t e;
        e.led = l;
        e.gap = g;
        sb.push_back(e);
    endtask

    // Counts falling edges until step_pulse is seen; -1 when the budget expires.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (step_pulse !== 1'b1 && n < 200);
        if (step_pulse !== 1'b1) n = -1;
    endtask

    task automatic do_reset(input logic e, input logic [1:0] m, input logic [1:0] s);
        sys_res_n = 1'b0;
        en        = e;
        mode      = m;
        speed     = s;
        sb.delete();
        repeat (2) @(negedge sys_clk);
        sys_res_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_res_n = 1'b0;
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL reset_led: got %b want %b", led, 4'b0001);
        end
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: got %b want 0", step_pulse);
        end
        sys_res_n = 1'b1;
        push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4); push(4'b0001, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL left_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL left_led: got %b want %b", led, e.led);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got %b want 0", step_pulse);
        end
    endtask

    task automatic test_bounce();
        do_reset(1'b1, 2'd2, 2'd0);
        push(4'b0001, 4); push(4'b0010, 4); push(4'b0100, 4); push(4'b1000, 4);
        push(4'b0100, 4); push(4'b0010, 4); push(4'b0001, 4); push(4'b0010, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL bounce_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL bounce_led: got %b want %b", led, e.led);
            end
        end
    endtask

    task automatic test_blink();
        do_reset(1'b1, 2'd3, 2'd1);
        push(4'b1111, 8); push(4'b0000, 8); push(4'b1111, 8); push(4'b0000, 8);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL blink_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL blink_led: got %b want %b", led, e.led);
            end
        end
    endtask

    task automatic test_mode_change();
        do_reset(1'b1, 2'd0, 2'd0);
        push(4'b0010, 4); push(4'b0100, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (led !== e.led || n !== e.gap) begin
                errors++;
                $display("FAIL pre_change: got %b/%0d want %b/%0d", led, n, e.led, e.gap);
            end
        end
        mode = 2'd1;
        push(4'b1000, 4); push(4'b0100, 4); push(4'b0010, 4); push(4'b0001, 4);
        push(4'b1000, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL right_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL right_led: got %b want %b", led, e.led);
            end
        end
        @(negedge sys_clk);
        mode = 2'd2;
        @(negedge sys_clk);
        mode = 2'd1;
        push(4'b0100, 2);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (led !== e.led || n !== e.gap) begin
                errors++;
                $display("FAIL glitch: got %b/%0d want %b/%0d", led, n, e.led, e.gap);
            end
        end
    endtask

    task automatic test_pause();
        do_reset(1'b1, 2'd0, 2'd0);
        push(4'b0010, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (led !== e.led || n !== e.gap) begin
                errors++;
                $display("FAIL pause_pre: got %b/%0d want %b/%0d", led, n, e.led, e.gap);
            end
        end
        repeat (2) @(negedge sys_clk);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            checks++;
            if (step_pulse !== 1'b0 || led !== 4'b0010) begin
                errors++;
                $display("FAIL pause_hold: cycle %0d got %b/%b want 0010/0", i, led, step_pulse);
            end
        end
        en = 1'b1;
        push(4'b0100, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL resume_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL resume_led: got %b want %b", led, e.led);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 2'd0, 2'd0);
        push(4'b0010, 4);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (led !== e.led || n !== e.gap) begin
                errors++;
                $display("FAIL areset_pre: got %b/%0d want %b/%0d", led, n, e.led, e.gap);
            end
        end
        speed = 2'd3;
        #2;
        sys_res_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL areset_led: got %b want %b", led, 4'b0001);
        end
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL areset_pulse: got %b want 0", step_pulse);
        end
        repeat (2) @(negedge sys_clk);
        sys_res_n = 1'b1;
        push(4'b0010, 32); push(4'b0100, 32);
        while (sb.size() > 0) begin
            exp_t e;
            int   n;
            e = sb.pop_front();
            wait_step(n);
            checks++;
            if (n !== e.gap) begin
                errors++;
                $display("FAIL slow_gap: got %0d want %0d", n, e.gap);
            end
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL slow_led: got %b want %b", led, e.led);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_blink();
        test_mode_change();
        test_pause();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flow_led_multi.md
Name: flow_led_multi

Overview:
Parametrised LED pattern engine, the successor to the fixed 4-LED rotator on the board LED bank. It drives LED_NUM outputs with four selectable patterns, a runtime-selectable step period and an enable/pause input. Step timing is derived from sys_clk through a prescaler and a speed divider. It sits between the board key/switch logic (mode, speed, en) and the LED pins.

Parameters:
LED_NUM, 4, number of LEDs driven (legal range 2..32)
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
STEP_MS, 200, base step period in ms; STEP_CYC = CLK_FREQ/1000*STEP_MS cycles (must be >= 2)

Ports:
sys_clk  input  1  system clock
sys_res_n  input  1  asynchronous active-low reset
en  input  1  1 = run; 0 = pause (LEDs hold, prescaler cleared)
mode  input  2  0 rotate left, 1 rotate right, 2 bounce, 3 blink all
speed  input  2  step period = STEP_CYC * 2^speed cycles
led  output  LED_NUM  LED drive, 1 = on
step_pulse  output  1  one-cycle strobe, high in the first cycle led shows a new value

Behaviour:
- Clock/reset: single clock sys_clk; sys_res_n asynchronous assert, active-low. All state is reset: led = 1 (bit0 only), step_pulse = 0, prescaler = 0, speed divider = 0, mode_q = 0, dir = up.
- Prescaler: counts 0..STEP_CYC-1 and wraps. base_tick = (prescaler == STEP_CYC-1) && en.
- Speed divider: div_cnt counts base_ticks 0..2^speed-1. step = base_tick && (div_cnt == 2^speed-1); div_cnt wraps to 0 on step. speed is sampled live. If a speed change leaves div_cnt > 2^speed-1, div_cnt resets to 0 on the next base_tick without stepping.
- en = 0: prescaler and div_cnt are held at 0. led, dir and mode_q are held. No step_pulse. On re-enable, the first step occurs a full period (STEP_CYC*2^speed cycles) after en rises.
- On step, registered; the new led value is visible the next cycle, together with step_pulse = 1:
  - If mode != mode_q: mode_q <= mode and led is reloaded with the seed of the new mode instead of advancing. Seeds: left/bounce = bit0 with dir = up; right = bit LED_NUM-1; blink = all ones.
  - Else mode 0 (left): led <= {led[LED_NUM-2:0], led[LED_NUM-1]}.
  - mode 1 (right): led <= {led[0], led[LED_NUM-1:1]}.
  - mode 2 (bounce): single lit LED moves one position in dir. When the next position would be an endpoint (bit LED_NUM-1 going up, bit 0 going down), move there and flip dir. Endpoints are shown once per pass: 0001,0010,0100,1000,0100,0010,0001,0010...
  - mode 3 (blink): led <= ~led. From the seed the output alternates all-on/all-off.
- Rotate modes preserve any pattern already in led (no one-hot check). Only a mode change or reset reseeds.
- Mode changes between steps take effect at the next step only; glitches on mode that clear before that step are ignored.
- Reset mid-period: counters clear immediately and led = 1. The first step comes STEP_CYC*2^speed cycles after deassertion.
- step_pulse is never high on two consecutive cycles (STEP_CYC >= 2).

Test Plan:
(Bench overrides: CLK_FREQ=1000, STEP_MS=4, so STEP_CYC=4; LED_NUM=4.)
1. Reset, en=1, mode=0, speed=0 -> led 0001,0010,0100,1000,0001 at 4-cycle spacing; step_pulse high 1 cycle at each change; first change 4 cycles after reset release.
2. mode=2, speed=0, run 8 steps from reset -> led sequence 0001(reseed since mode_q=0→2),0010,0100,1000,0100,0010,0001,0010.
3. mode=3, speed=1 -> first step reseeds 1111, then 0000,1111 every 8 cycles.
4. mode=0 running at led=0100, change mode to 1 mid-period -> next step led=1000 (right seed); following steps 0100,0010,0001,1000.
5. en=0 for 20 cycles mid-period at led=0010 -> led holds 0010 with no step_pulse; after en=1 the next change comes exactly 4 cycles later to 0100.
6. speed=3, assert sys_res_n=0 asynchronously mid-period -> led=0001 and step_pulse=0 immediately; first step 32 cycles after release.
